// File: rtl/alu_arbiter.sv
// Shares one 16-bit ALU between two requesters: arbitrates one op per cycle and returns
// each result plus flags through a per-requester valid/ready response register.
module alu_arbiter #(
  parameter int PRIO_FIXED   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_data,
  output logic [2:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_data,
  output logic [2:0]  rsp1_flags
);

  localparam logic [3:0] NOP_OP     = 4'hF;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic       elig0, elig1;
  logic       grant0, grant1;
  logic       last_grant;
  logic [3:0] starve_cnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt < STARVE_MAX) ? cnt + 4'd1 : STARVE_MAX;
  endfunction

  // Stage 0: arbitration and ALU drive (combinational)
  always_comb begin
    elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (PRIO_FIXED != 0) begin
        grant1 = (starve_cnt == STARVE_MAX);
        grant0 = !grant1;
      end else begin
        // last_grant == 1 means req1 won last, so req0 takes the tie
        grant0 = last_grant;
        grant1 = !last_grant;
      end
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_opcode = NOP_OP;
    alu_in1    = '0;
    alu_in2    = '0;
    if (grant0) begin
      alu_opcode = req0_opcode;
      alu_in1    = req0_a;
      alu_in2    = req0_b;
    end else if (grant1) begin
      alu_opcode = req1_opcode;
      alu_in1    = req1_a;
      alu_in2    = req1_b;
    end
  end

  // Stage 1: response capture and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_flags <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_flags <= '0;
      last_grant <= 1'b1;
      starve_cnt <= '0;
    end else begin
      if (grant0) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= alu_result;
        rsp0_flags <= alu_flags;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= alu_result;
        rsp1_flags <= alu_flags;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      if (grant1) begin
        starve_cnt <= '0;
      end else if (elig1) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule
